// File: rtl/regfile_dbg_arbiter.sv
// Arbitrates the register file between core pipeline and debug: stalls the core,
// waits for quiesce (with timeout), performs one access, returns a valid/ready response.
module regfile_dbg_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  core_rs1_i,
  input  logic [4:0]  core_rs2_i,
  input  logic        core_we_i,
  input  logic [4:0]  core_ws_i,
  input  logic [31:0] core_wd_i,
  output logic        core_stall_o,
  input  logic        core_idle_i,
  input  logic        dbg_req_valid_i,
  output logic        dbg_req_ready_o,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_rsp_valid_o,
  input  logic        dbg_rsp_ready_i,
  output logic [31:0] dbg_rsp_data_o,
  output logic        dbg_rsp_err_o,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_ws_o,
  output logic [31:0] rf_wd_o,
  input  logic [31:0] rf_rd1_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIESCE,
    S_ACCESS,
    S_RDWAIT,
    S_RESP
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (dbg_req_valid_i) begin
          we_d    = dbg_we_i;
          addr_d  = dbg_addr_i;
          wdata_d = dbg_wdata_i;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        // An idle core in the same cycle as the last count still gets its access.
        if (core_idle_i) begin
          state_d = S_ACCESS;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACCESS: begin
        state_d = we_q ? S_RESP : S_RDWAIT;
      end
      S_RDWAIT: begin
        rdata_d = (addr_q == 5'd0) ? 32'd0 : rf_rd1_i;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (dbg_rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic in_access;
  assign in_access = (state_q == S_ACCESS);

  assign dbg_req_ready_o = (state_q == S_IDLE);
  assign core_stall_o    = (state_q != S_IDLE);
  assign dbg_rsp_valid_o = (state_q == S_RESP);
  assign dbg_rsp_data_o  = rdata_q;
  assign dbg_rsp_err_o   = err_q;

  // Write port decodes from current state, so a reset during ACCESS still writes.
  assign rf_rs1_o = in_access ? addr_q : core_rs1_i;
  assign rf_rs2_o = core_rs2_i;
  assign rf_we_o  = in_access ? we_q : core_we_i;
  assign rf_ws_o  = in_access ? addr_q : core_ws_i;
  assign rf_wd_o  = in_access ? wdata_q : core_wd_i;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Directed bench for regfile_dbg_arbiter with a transaction-timing model and a
// bench-side register file; the model is checked every cycle.
module tb_regfile_dbg_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  core_rs1_i, core_rs2_i, core_ws_i;
  logic        core_we_i, core_idle_i;
  logic [31:0] core_wd_i;
  logic        core_stall_o;
  logic        dbg_req_valid_i, dbg_req_ready_o, dbg_we_i;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_rsp_valid_o, dbg_rsp_ready_i, dbg_rsp_err_o;
  logic [31:0] dbg_rsp_data_o;
  logic [4:0]  rf_rs1_o, rf_rs2_o, rf_ws_o;
  logic        rf_we_o;
  logic [31:0] rf_wd_o, rf_rd1_i;

  regfile_dbg_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_rs1_i(core_rs1_i), .core_rs2_i(core_rs2_i),
    .core_we_i(core_we_i), .core_ws_i(core_ws_i), .core_wd_i(core_wd_i),
    .core_stall_o(core_stall_o), .core_idle_i(core_idle_i),
    .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rsp_valid_o(dbg_rsp_valid_o), .dbg_rsp_ready_i(dbg_rsp_ready_i),
    .dbg_rsp_data_o(dbg_rsp_data_o), .dbg_rsp_err_o(dbg_rsp_err_o),
    .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .rf_we_o(rf_we_o), .rf_ws_o(rf_ws_o), .rf_wd_o(rf_wd_o),
    .rf_rd1_i(rf_rd1_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file seen by the DUT: registered read port, x0 never written.
  bit [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_we_o && rf_ws_o != 5'd0) rf_mem[rf_ws_o] <= rf_wd_o;
    rf_rd1_i <= rf_mem[rf_rs1_o];
  end

  int vec = 0;
  int miscmp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: accept time, access time and response time by arithmetic.
  bit        m_known = 1'b0;
  bit        m_busy = 1'b0;
  int        m_t = 0, m_acc_t = -1, m_resp_t = -1;
  bit        m_we, m_err;
  bit [4:0]  m_addr;
  bit [31:0] m_wdata, m_data;
  bit [31:0] shadow [32];

  initial forever begin
    logic       in_acc, e_we, e_vld;
    logic [4:0] e_ws;
    logic [31:0] e_wd;
    @(negedge clk);
    in_acc = m_busy && (m_acc_t == cyc);
    e_vld  = m_busy && (m_resp_t >= 0) && (cyc >= m_resp_t);
    e_we   = in_acc ? m_we : core_we_i;
    e_ws   = in_acc ? m_addr : core_ws_i;
    e_wd   = in_acc ? m_wdata : core_wd_i;
    if (m_known) begin
      chk("stall", core_stall_o, m_busy);
      chk("req_ready", dbg_req_ready_o, !m_busy);
      chk("rsp_valid", dbg_rsp_valid_o, e_vld);
      chk("rf_rs2", rf_rs2_o, core_rs2_i);
      chk("rf_rs1", rf_rs1_o, in_acc ? m_addr : core_rs1_i);
      chk("rf_we", rf_we_o, e_we);
      if (e_we) begin
        chk("rf_ws", rf_ws_o, e_ws);
        chk("rf_wd", rf_wd_o, e_wd);
      end
      if (e_vld) begin
        chk("rsp_data", dbg_rsp_data_o, m_data);
        chk("rsp_err", dbg_rsp_err_o, m_err);
      end
      if (in_acc && !m_we) m_data = shadow[m_addr];
      if (e_we && e_ws != 5'd0) shadow[e_ws] = e_wd;
    end
    if (rst_i) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (dbg_req_valid_i) begin
          m_busy = 1'b1; m_t = cyc; m_acc_t = -1; m_resp_t = -1;
          m_we = dbg_we_i; m_addr = dbg_addr_i; m_wdata = dbg_wdata_i;
          m_data = 32'd0; m_err = 1'b0;
        end
      end else if (e_vld) begin
        if (dbg_rsp_ready_i) m_busy = 1'b0;
      end else if (m_acc_t < 0 && m_resp_t < 0) begin
        if (core_idle_i) begin
          m_acc_t  = cyc + 1;
          m_resp_t = cyc + 1 + (m_we ? 1 : 2);
        end else if (cyc - (m_t + 1) == TO - 1) begin
          m_resp_t = cyc + 1;
          m_err    = 1'b1;
          m_data   = 32'd0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    core_rs1_i = 5'(cyc * 3);
    core_rs2_i = 5'(cyc * 7 + 1);
  endtask

  task automatic send(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                      output int t);
    dbg_req_valid_i = 1'b1;
    dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd;
    t = cyc;
    chk("send_ready", dbg_req_ready_o, 1'b1);
    tick();
    dbg_req_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!dbg_rsp_valid_o && n < 50) begin
      tick();
      n++;
    end
    if (!dbg_rsp_valid_o) chk("rsp_wait_bound", dbg_rsp_valid_o, 1'b1);
  endtask

  task automatic wait_rsp(input int t, output int lat, output logic [31:0] d, output logic e);
    wait_valid();
    lat = cyc - t;
    d = dbg_rsp_data_o;
    e = dbg_rsp_err_o;
    dbg_rsp_ready_i = 1'b1;
    tick();
    dbg_rsp_ready_i = 1'b0;
    chk("stall_after_hs", core_stall_o, 1'b0);
  endtask

  initial begin
    int t, lat;
    logic [31:0] d;
    logic e;
    rst_i = 1'b1;
    core_rs1_i = '0; core_rs2_i = '0; core_we_i = 1'b0; core_ws_i = '0; core_wd_i = '0;
    core_idle_i = 1'b1;
    dbg_req_valid_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    dbg_rsp_ready_i = 1'b0;
    tick();
    chk("reset_stall", core_stall_o, 1'b0);
    chk("reset_ready", dbg_req_ready_o, 1'b1);
    chk("reset_valid", dbg_rsp_valid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();

    // Write x5 with an idle core.
    send(1'b1, 5'd5, 32'hDEADBEEF, t);
    tick();
    chk("wr_we_T2", rf_we_o, 1'b1);
    chk("wr_ws_T2", rf_ws_o, 32'd5);
    chk("wr_wd_T2", rf_wd_o, 32'hDEADBEEF);
    wait_rsp(t, lat, d, e);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_data", d, 32'd0);
    chk("wr_err", e, 1'b0);

    send(1'b0, 5'd5, 32'd0, t);
    wait_rsp(t, lat, d, e);
    chk("rd5_lat", 32'(lat), 32'd4);
    chk("rd5_data", d, 32'hDEADBEEF);

    // Read x0 while the core keeps writing x7.
    core_we_i = 1'b1; core_ws_i = 5'd7; core_wd_i = 32'h77;
    send(1'b0, 5'd0, 32'd0, t);
    chk("core_wr_before", rf_we_o, 1'b1);
    tick();
    chk("core_wr_suppressed", rf_we_o, 1'b0);
    chk("acc_rs1_x0", rf_rs1_o, 32'd0);
    tick();
    chk("core_wr_after", rf_we_o, 1'b1);
    wait_rsp(t, lat, d, e);
    chk("rd0_lat", 32'(lat), 32'd4);
    chk("rd0_data", d, 32'd0);
    core_we_i = 1'b0;
    send(1'b0, 5'd7, 32'd0, t);
    wait_rsp(t, lat, d, e);
    chk("rd7_data", d, 32'h77);

    // Quiesce timeout.
    core_idle_i = 1'b0;
    send(1'b1, 5'd9, 32'h1234, t);
    wait_rsp(t, lat, d, e);
    chk("to_lat", 32'(lat), 32'd5);
    chk("to_err", e, 1'b1);
    chk("to_data", d, 32'd0);
    core_idle_i = 1'b1;
    send(1'b0, 5'd9, 32'd0, t);
    wait_rsp(t, lat, d, e);
    chk("to_no_write", d, 32'd0);

    // Late idle at T+3, core write passes during quiesce.
    core_idle_i = 1'b0;
    core_we_i = 1'b1; core_ws_i = 5'd3; core_wd_i = 32'h33;
    send(1'b1, 5'd10, 32'hA5A5, t);
    chk("quiesce_core_we", rf_we_o, 1'b1);
    chk("quiesce_core_ws", rf_ws_o, 32'd3);
    tick();
    tick();
    core_idle_i = 1'b1;
    tick();
    chk("late_acc_ws", rf_ws_o, 32'd10);
    chk("late_acc_wd", rf_wd_o, 32'hA5A5);
    core_we_i = 1'b0;
    wait_rsp(t, lat, d, e);
    chk("late_lat", 32'(lat), 32'd5);

    // Idle arriving on the last counted cycle beats the timeout.
    core_idle_i = 1'b0;
    send(1'b1, 5'd11, 32'h11, t);
    tick(); tick(); tick();
    core_idle_i = 1'b1;
    wait_rsp(t, lat, d, e);
    chk("race_lat", 32'(lat), 32'd6);
    chk("race_err", e, 1'b0);
    send(1'b0, 5'd11, 32'd0, t);
    wait_rsp(t, lat, d, e);
    chk("race_data", d, 32'h11);

    // Response back-pressure with a competing request.
    send(1'b0, 5'd5, 32'd0, t);
    wait_valid();
    dbg_req_valid_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd20; dbg_wdata_i = 32'hBAD;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", dbg_rsp_valid_o, 1'b1);
      chk("bp_data", dbg_rsp_data_o, 32'hDEADBEEF);
      chk("bp_stall", core_stall_o, 1'b1);
      chk("bp_req_ready", dbg_req_ready_o, 1'b0);
    end
    dbg_req_valid_i = 1'b0;
    dbg_rsp_ready_i = 1'b1;
    tick();
    dbg_rsp_ready_i = 1'b0;
    send(1'b1, 5'd12, 32'hC0FFEE, t);
    wait_rsp(t, lat, d, e);
    chk("b2b_lat", 32'(lat), 32'd3);
    send(1'b0, 5'd20, 32'd0, t);
    wait_rsp(t, lat, d, e);
    chk("bp_req_dropped", d, 32'd0);

    // Reset during QUIESCE.
    core_idle_i = 1'b0;
    send(1'b1, 5'd13, 32'h99, t);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstq_stall", core_stall_o, 1'b0);
    chk("rstq_valid", dbg_rsp_valid_o, 1'b0);
    chk("rstq_ready", dbg_req_ready_o, 1'b1);
    core_idle_i = 1'b1;
    tick(); tick();
    send(1'b0, 5'd13, 32'd0, t);
    wait_rsp(t, lat, d, e);
    chk("rstq_no_write", d, 32'd0);

    // Reset during RESP.
    send(1'b1, 5'd14, 32'h44, t);
    wait_valid();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rstr_stall", core_stall_o, 1'b0);
    chk("rstr_valid", dbg_rsp_valid_o, 1'b0);
    chk("rstr_ready", dbg_req_ready_o, 1'b1);
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vec, miscmp);
    $fatal(1, "watchdog");
  end

endmodule
